// File: rtl/sequenciador_musica.sv
// Song sequencer: walks a song ROM region, times each note with a ms tick and
// drives the tone generator with note code, enable and end-of-song pulse.
module sequenciador_musica #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 1000,
    parameter int GAP_TICKS = 20,
    parameter int ADDR_W    = 8,
    parameter int LOOP      = 0
) (
    input  logic              clk_placa,
    input  logic              rst,
    input  logic              stop_in,
    input  logic              play_in,
    input  logic [1:0]        sel_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [5:0]        nota_out,
    output logic              som_en,
    output logic              musica_fim,
    output logic              ocupado
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OFF_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_ROM, S_SOUND, S_GAP, S_NEXT, S_END, S_PAUSED
    } state_t;

    state_t             state_q, state_d, ret_q, ret_d, nat;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [5:0]         nota_q, nota_d;
    logic [9:0]         dur_q, dur_d, cnt_q, cnt_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               running, tick;

    assign running = (state_q == S_SOUND) || (state_q == S_GAP);
    assign tick    = running && (pre_q == PRE_W'(DIV - 1));

    always_ff @(posedge clk_placa) begin
        if (rst) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            addr_q  <= '0;
            nota_q  <= '0;
            dur_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            addr_q  <= addr_d;
            nota_q  <= nota_d;
            dur_q   <= dur_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        addr_d  = addr_q;
        nota_d  = nota_q;
        dur_d   = dur_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        nat     = state_q;

        if (running) pre_d = tick ? '0 : pre_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                addr_d = {sel_in, {OFF_W{1'b0}}};
                if (play_in && !stop_in) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_WAIT_ROM;
            S_WAIT_ROM: begin
                if (rom_data[15:10] == 6'h3F) begin
                    state_d = S_END;
                end else if (rom_data[9:0] == 10'd0) begin
                    state_d = S_NEXT;
                end else begin
                    nota_d  = rom_data[15:10];
                    dur_d   = rom_data[9:0];
                    cnt_d   = (int'(rom_data[9:0]) > GAP_TICKS) ?
                              rom_data[9:0] - 10'(GAP_TICKS) : rom_data[9:0];
                    ret_d   = S_SOUND;
                    // A pause requested while fetching lands here with the note latched
                    state_d = play_in ? S_SOUND : S_PAUSED;
                end
            end
            S_SOUND, S_GAP: begin
                if (tick) begin
                    if (cnt_q <= 10'd1) begin
                        if (state_q == S_SOUND && int'(dur_q) > GAP_TICKS && GAP_TICKS > 0) begin
                            nat   = S_GAP;
                            cnt_d = 10'(GAP_TICKS);
                        end else begin
                            nat   = S_NEXT;
                            cnt_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
                ret_d   = nat;
                state_d = play_in ? nat : S_PAUSED;
            end
            S_NEXT: begin
                addr_d[OFF_W-1:0] = addr_q[OFF_W-1:0] + 1'b1;
                state_d = (&addr_q[OFF_W-1:0]) ? S_END : S_FETCH;
            end
            S_END: begin
                if (LOOP != 0 && play_in) begin
                    addr_d  = {addr_q[ADDR_W-1:ADDR_W-2], {OFF_W{1'b0}}};
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PAUSED: if (play_in) state_d = ret_q;
            default: state_d = S_IDLE;
        endcase

        // Stop overrides every internal transition, END included
        if (stop_in && state_q != S_IDLE) begin
            state_d = S_IDLE;
            nota_d  = '0;
            dur_d   = '0;
            cnt_d   = '0;
            pre_d   = '0;
            addr_d  = {addr_q[ADDR_W-1:ADDR_W-2], {OFF_W{1'b0}}};
        end

        if (state_d == S_FETCH) pre_d = '0;
    end

    assign rom_addr   = addr_q;
    assign nota_out   = nota_q;
    assign som_en     = (state_q == S_SOUND) && (nota_q != 6'h00);
    assign musica_fim = (state_q == S_END);
    assign ocupado    = (state_q != S_IDLE);
endmodule
